rx_synch_ctrl: RTL

Receive-side sequencer for the 802.16 OFDM time-synchronisation stage. It arms the time-sync block (`syn_run`), supervises the preamble search with a sample-count timeout and bounded retries, and captures the coarse frequency metric `FRE_O`. On lock it hands that metric and a frame-start strobe to the CFO/FFT path. It sits between the receiver top-level control and the time-sync datapath.

---
 rtl/rx_synch_pkg.sv | 19 +
 rtl/synch_tmo_cnt.sv | 39 +++
 rtl/rx_synch_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/rx_synch_pkg.sv
// Shared definitions for the receive-side time-sync sequencer.
package rx_synch_pkg;

  // Width of the coarse frequency metric {Im[15:0], Re[15:0]}.
  localparam int unsigned FRE_W = 32;

  // Shortest usable hold-off. The time-sync block needs at least this many
  // cycles with syn_run low to flush its internal counters.
  localparam int unsigned HOLDOFF_MIN = 2;

  typedef enum logic [2:0] {
    StIdle,
    StSearch,
    StHold,
    StLocked,
    StFail
  } state_e;

endpackage

// File: rtl/synch_tmo_cnt.sv
// Saturating search timeout counter. It counts valid samples and flags the
// sample that brings the count up to the terminal value.
module synch_tmo_cnt #(
  parameter int unsigned     W  = 16,
  parameter logic [W-1:0]    TC = '1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_hit,
  output logic o_tc
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_next;
  logic         w_sat;

  // Next count and the terminal-count decodes.
  always_comb begin
    w_sat  = &r_cnt;
    w_next = r_cnt + 1'b1;
    // Fires on the increment that makes the count equal TC.
    o_hit  = i_inc && !w_sat && (w_next == TC);
    o_tc   = (r_cnt >= TC);
  end

  // Count register: clear has priority, increments stop at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_sat) begin
      r_cnt <= w_next;
    end
  end

endmodule

// File: rtl/rx_synch_ctrl.sv
// Receive-side time-sync sequencer: arms the time-sync block, supervises the
// preamble search with a sample timeout and bounded retries, and hands the
// captured coarse frequency metric to the CFO/FFT path on lock.
// Optional statistics counters are enabled by defining RX_SYNCH_STATS_EN.
module rx_synch_ctrl
  import rx_synch_pkg::*;
#(
  parameter int unsigned         TMO_W     = 16,
  parameter logic [TMO_W-1:0]    TMO_DEF   = 16'd4000,
  parameter int unsigned         HOLDOFF   = 8,
  parameter int unsigned         MAX_RETRY = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_smp_val,
  input  logic             i_syn_done,
  input  logic             i_fre_in_val,
  input  logic [FRE_W-1:0] i_fre_in,
  output logic             o_syn_run,
  output logic [FRE_W-1:0] o_fre_out,
  output logic             o_fre_out_val,
  output logic             o_frame_start,
  output logic             o_locked,
  output logic             o_sync_fail,
  output logic [3:0]       o_retry_cnt
`ifdef RX_SYNCH_STATS_EN
  ,
  input  logic             i_stat_clr,
  output logic [15:0]      o_stat_lock,
  output logic [15:0]      o_stat_tmo
`endif
);

  // Hold-off is clamped so the time-sync block always gets a flush.
  localparam int unsigned HoldCycles = (HOLDOFF < HOLDOFF_MIN) ? HOLDOFF_MIN : HOLDOFF;
  localparam int unsigned HoldW      = $clog2(HoldCycles);

  state_e             r_state;
  logic [FRE_W-1:0]   r_stage;
  logic               r_cap;
  logic [HoldW-1:0]   r_hold_cnt;

  logic               w_tmo_clr;
  logic               w_tmo_inc;
  logic               w_tmo_hit;
  logic               w_tmo_tc;
  logic               w_in_search;
  logic               w_cap_any;
  logic               w_lock;
  logic               w_fail;
  logic               w_retry_ok;
  logic [FRE_W-1:0]   w_lock_val;

  // Counter only runs in SEARCH and is held at zero elsewhere, so every
  // entry into SEARCH starts from a clean count.
  synch_tmo_cnt #(
    .W  (TMO_W),
    .TC (TMO_DEF)
  ) u_tmo_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_tmo_clr),
    .i_inc   (w_tmo_inc),
    .o_hit   (w_tmo_hit),
    .o_tc    (w_tmo_tc)
  );

  // Search-phase event decode with stop > syn_done > timeout priority.
  always_comb begin
    w_tmo_clr   = (r_state != StSearch);
    w_tmo_inc   = (r_state == StSearch) && i_smp_val;
    w_in_search = (r_state == StSearch) && !i_stop;
    // A metric arriving with syn_done counts as captured and is the one locked.
    w_cap_any   = r_cap || i_fre_in_val;
    w_lock_val  = i_fre_in_val ? i_fre_in : r_stage;
    w_lock      = w_in_search && i_syn_done && w_cap_any;
    w_fail      = w_in_search &&
                  ((i_syn_done && !w_cap_any) || (!i_syn_done && (w_tmo_hit || w_tmo_tc)));
    w_retry_ok  = (32'(o_retry_cnt) < MAX_RETRY);
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= StIdle;
      r_stage       <= '0;
      r_cap         <= 1'b0;
      r_hold_cnt    <= '0;
      o_syn_run     <= 1'b0;
      o_fre_out     <= '0;
      o_fre_out_val <= 1'b0;
      o_frame_start <= 1'b0;
      o_locked      <= 1'b0;
      o_sync_fail   <= 1'b0;
      o_retry_cnt   <= '0;
    end else begin
      o_fre_out_val <= 1'b0;
      o_frame_start <= 1'b0;
      if (i_stop) begin
        r_state     <= StIdle;
        o_syn_run   <= 1'b0;
        o_locked    <= 1'b0;
        o_sync_fail <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (i_start) begin
              r_state     <= StSearch;
              r_cap       <= 1'b0;
              o_syn_run   <= 1'b1;
              o_retry_cnt <= '0;
            end
          end
          StSearch: begin
            if (i_fre_in_val) begin
              r_stage <= i_fre_in;
              r_cap   <= 1'b1;
            end
            if (w_lock) begin
              r_state       <= StLocked;
              o_syn_run     <= 1'b0;
              o_locked      <= 1'b1;
              o_fre_out     <= w_lock_val;
              o_fre_out_val <= 1'b1;
              o_frame_start <= 1'b1;
            end else if (w_fail) begin
              o_syn_run <= 1'b0;
              if (w_retry_ok) begin
                r_state     <= StHold;
                r_hold_cnt  <= HoldW'(HoldCycles - 1);
                o_retry_cnt <= o_retry_cnt + 4'd1;
              end else begin
                r_state     <= StFail;
                o_sync_fail <= 1'b1;
              end
            end
          end
          StHold: begin
            if (r_hold_cnt == '0) begin
              r_state   <= StSearch;
              r_cap     <= 1'b0;
              o_syn_run <= 1'b1;
            end else begin
              r_hold_cnt <= r_hold_cnt - 1'b1;
            end
          end
          StLocked: begin
            // Held until stop; start is ignored here.
          end
          StFail: begin
            if (i_start) begin
              r_state     <= StSearch;
              r_cap       <= 1'b0;
              o_syn_run   <= 1'b1;
              o_sync_fail <= 1'b0;
              o_retry_cnt <= '0;
            end
          end
          default: begin
            r_state   <= StIdle;
            o_syn_run <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef RX_SYNCH_STATS_EN
  // Saturating lock and failed-attempt counters with synchronous clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stat_lock <= '0;
      o_stat_tmo  <= '0;
    end else if (i_stat_clr) begin
      o_stat_lock <= '0;
      o_stat_tmo  <= '0;
    end else begin
      if (w_lock && (o_stat_lock != 16'hFFFF)) begin
        o_stat_lock <= o_stat_lock + 16'd1;
      end
      if (w_fail && (o_stat_tmo != 16'hFFFF)) begin
        o_stat_tmo <= o_stat_tmo + 16'd1;
      end
    end
  end
`endif

endmodule
